id_exe_reg: RTL

- Receiving end of the decode-stage output bundle: the ID/EXE pipeline register.
- Captures the control/data bundle produced by decode each cycle, plus the instruction PC, and presents it registered to the execute stage.
- Supports a pipeline freeze (memory stall) and a flush (taken branch), and tracks slot validity.
- Sits between the decode stage and the execute stage, the ALU and the status register.

---
 rtl/arm_pkg.sv | 47 ++++
 rtl/pipe_reg_en_clr.sv | 26 ++
 rtl/id_exe_reg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared decode/execute types: ALU command encoding, ID/EXE control bundle and datapath fields.
// Types only; no timing or flow-control behaviour of its own.
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'h0,
    CMD_MOV = 4'h1,
    CMD_ADD = 4'h2,
    CMD_ADC = 4'h3,
    CMD_SUB = 4'h4,
    CMD_SBC = 4'h5,
    CMD_AND = 4'h6,
    CMD_ORR = 4'h7,
    CMD_EOR = 4'h8,
    CMD_MVN = 4'h9,
    CMD_CMP = 4'hA,
    CMD_TST = 4'hB,
    CMD_LDR = 4'hC,
    CMD_STR = 4'hD
  } exe_cmd_t;

  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_t exe_cmd;
  } id_exe_ctrl_t;

  localparam id_exe_ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } id_exe_data_t;

  // Enough for FLUSH_DEPTH up to 3 (reload value 2).
  localparam int unsigned SHADOW_W = 2;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset, enable, synchronous clear (enable wins over clear).
// One cycle latency; en=0 holds the stored value.
module pipe_reg_en_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= clr ? '0 : d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: 1-cycle latency; freeze holds all state, flush inserts FLUSH_DEPTH bubbles.
// Optional perf counters (bubble_cnt, stall_cnt) enabled by ID_EXE_PERF_CNT_EN.
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            freeze,
  input  logic            flush,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_wb_en,
  input  logic            id_mem_r_en,
  input  logic            id_mem_w_en,
  input  logic            id_b,
  input  logic            id_s,
  input  logic [3:0]      id_exe_cmd,
  input  logic [31:0]     id_val_rn,
  input  logic [31:0]     id_val_rm,
  input  logic            id_imm,
  input  logic [11:0]     id_shift_operand,
  input  logic [23:0]     id_signed_imm_24,
  input  logic [3:0]      id_dest,
  input  logic [3:0]      id_src1,
  input  logic [3:0]      id_src2,
  output logic [PC_W-1:0] exe_pc,
  output logic            exe_wb_en,
  output logic            exe_mem_r_en,
  output logic            exe_mem_w_en,
  output logic            exe_b,
  output logic            exe_s,
  output logic [3:0]      exe_exe_cmd,
  output logic [31:0]     exe_val_rn,
  output logic [31:0]     exe_val_rm,
  output logic            exe_imm,
  output logic [11:0]     exe_shift_operand,
  output logic [23:0]     exe_signed_imm_24,
  output logic [3:0]      exe_dest,
  output logic [3:0]      exe_src1,
  output logic [3:0]      exe_src2,
  output logic            exe_valid,
  output logic            flush_active
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int DATA_W = PC_W + $bits(id_exe_data_t);
  localparam logic [SHADOW_W-1:0] SHADOW_RELOAD = SHADOW_W'(FLUSH_DEPTH - 1);

  id_exe_ctrl_t        ctrl_d, ctrl_q;
  id_exe_data_t        dp_d, dp_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   data_d, data_q;
  logic [SHADOW_W-1:0] shadow_d, shadow_q;
  logic                valid_d, valid_q;
  logic                bubble;

  assign ctrl_d = '{
    wb_en:    id_wb_en,
    mem_r_en: id_mem_r_en,
    mem_w_en: id_mem_w_en,
    b:        id_b,
    s:        id_s,
    exe_cmd:  exe_cmd_t'(id_exe_cmd)
  };

  assign dp_d = '{
    val_rn:        id_val_rn,
    val_rm:        id_val_rm,
    imm:           id_imm,
    shift_operand: id_shift_operand,
    signed_imm_24: id_signed_imm_24,
    dest:          id_dest,
    src1:          id_src1,
    src2:          id_src2
  };

  assign data_d = {id_pc, dp_d};

  // A flush or a live shadow count both kill the incoming instruction.
  assign bubble = flush || (shadow_q != '0);

  always_comb begin
    shadow_d = shadow_q;
    valid_d  = !bubble;
    if (flush) begin
      shadow_d = SHADOW_RELOAD;
    end else if (shadow_q != '0) begin
      shadow_d = shadow_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else if (!freeze) begin
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  pipe_reg_en_clr #(.W($bits(id_exe_ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (!freeze),
    .clr   (bubble),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  // Datapath is never cleared; it is meaningless while the control bits are zero.
  pipe_reg_en_clr #(.W(DATA_W)) u_data_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (!freeze),
    .clr   (1'b0),
    .d     (data_d),
    .q     (data_q)
  );

  assign {pc_q, dp_q} = data_q;

  assign exe_pc            = pc_q;
  assign exe_wb_en         = ctrl_q.wb_en;
  assign exe_mem_r_en      = ctrl_q.mem_r_en;
  assign exe_mem_w_en      = ctrl_q.mem_w_en;
  assign exe_b             = ctrl_q.b;
  assign exe_s             = ctrl_q.s;
  assign exe_exe_cmd       = ctrl_q.exe_cmd;
  assign exe_val_rn        = dp_q.val_rn;
  assign exe_val_rm        = dp_q.val_rm;
  assign exe_imm           = dp_q.imm;
  assign exe_shift_operand = dp_q.shift_operand;
  assign exe_signed_imm_24 = dp_q.signed_imm_24;
  assign exe_dest          = dp_q.dest;
  assign exe_src1          = dp_q.src1;
  assign exe_src2          = dp_q.src2;
  assign exe_valid         = valid_q;
  assign flush_active      = (shadow_q != '0);

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (freeze) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else if (bubble || (ctrl_d == CTRL_BUBBLE)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
